bc_temporizador: RTL and testbench
==================================

# bc_temporizador

Parametrised countdown control block with integrated datapath. It is the successor of the fixed 2-bit start/zero/pronto controller. It loads a WIDTH-bit value on `start` and decrements it to zero, and it signals completion with a one-cycle pulse. It optionally auto-reloads and counts completed periods. It sits between a host-side start/abort interface and any logic that needs a programmable delay or periodic tick.

## Interface
- `WIDTH`, 8, width of load value and counter (≥2)
- `PRESC`, 4, clock cycles per decrement when prescaler is compiled in (≥1)
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset (`rst`=0 resets immediately)
- `start` in 1: begin countdown; sampled only in OCIOSO
- `abort` in 1: cancel countdown; sampled in every state
- `auto` in 1: reload mode; sampled in FIM
- `valor` in WIDTH: load value; sampled in CARGA
- `cont` out WIDTH: current counter value
- `voltas` out 8: completed countdowns, saturating
- `ocupado` out 1: state ≠ OCIOSO
- `pronto` out 1: state = OCIOSO
- `fim` out 1: high for exactly the cycle spent in FIM

## Operation
- FSM, 2-bit registered state: OCIOSO=00, CARGA=01, DECREMENTA=10, FIM=11. Outputs are decoded from the state and registers only.
- Reset values: state OCIOSO, `cont`=0, `voltas`=0, `pronto`=1, `ocupado`=0, `fim`=0, prescaler=0.
- OCIOSO:
  - `start`=1 and `abort`=0 → CARGA, and `voltas` is cleared to 0.
  - Otherwise the FSM stays in OCIOSO.
- CARGA:
  - `cont`←`valor` and the prescaler is cleared.
  - `valor`=0 → FIM. Otherwise → DECREMENTA.
- DECREMENTA:
  - On each tick, `cont`←`cont`−1.
  - When a tick occurs with `cont`=1, `cont`←0 and → FIM.
  - `cont` never wraps below 0.
- FIM:
  - `voltas`←`voltas`+1, saturating at 255.
  - `auto`=1 → CARGA, re-sampling `valor`. Otherwise → OCIOSO.
- `abort`=1 in CARGA, DECREMENTA or FIM → OCIOSO next edge, with `cont`←0.
  - `voltas` is not incremented when `abort` is taken in FIM.
  - `abort` has priority over every other transition.
- `start` is ignored outside OCIOSO. `start` and `abort` asserted together in OCIOSO: the FSM stays in OCIOSO.
- `valor` changes during DECREMENTA have no effect until the next CARGA.
- Reset asserted mid-count forces the reset values asynchronously. After release, the FSM waits in OCIOSO for a new `start`.

## Timing
- Tick without prescaler: every cycle in DECREMENTA.
- Edge numbering: edge 0 samples `start`.
  - Edge 1 loads `cont`=N.
  - Edge 1+N·P gives `cont`=0 and state FIM (P = tick period).
  - `fim` is high for the single cycle between edges 1+N·P and 2+N·P.
  - `pronto` returns to 1 after edge 2+N·P.
- `valor`=0: FIM after edge 1, OCIOSO after edge 2.
- Auto-reload:
  - FIM→CARGA→DECREMENTA adds 2 cycles per period.
  - Period = N·P+2 cycles, and `fim` pulses once per period.
- `abort`: takes effect at the next edge. `fim` is never asserted for an aborted run.

## Configuration
- `BC_PRESCALER_EN` defined:
  - Internal counter of width $clog2(PRESC+1).
  - The counter runs only in DECREMENTA and is cleared in CARGA.
  - A tick is generated when the counter reaches PRESC−1, and the counter then wraps to 0.
  - P = PRESC.
  - PRESC=1 behaves identically to the undefined case.
- `BC_PRESCALER_EN` undefined: no prescaler logic, `PRESC` is ignored, P = 1.

## Test plan
- Reset check: pull `rst`=0 mid-count with `cont`=5 → all outputs return to reset values immediately; after release, `pronto`=1 and `cont`=0.
- One-shot, no prescaler, WIDTH=8: `valor`=5, `start` pulse at edge 0 → `cont` takes 5,4,3,2,1,0 on edges 1–6, `fim`=1 only after edge 6, `pronto`=1 after edge 7, `voltas`=1.
- Zero load: `valor`=0, `start` → `fim` after edge 1, OCIOSO after edge 2, `voltas`=1, `cont` stays 0.
- Auto-reload: `valor`=3, `auto`=1, run for 3 periods → `fim` pulses every 5 cycles, `voltas`=3.
  - Then drop `auto` → OCIOSO after the next FIM.
  - Saturation: force 260 periods → `voltas`=255.
- Abort and priority:
  - `abort` at `cont`=2 → OCIOSO next edge, `cont`=0, no `fim`, `voltas` unchanged.
  - `start`+`abort` in OCIOSO → stays OCIOSO.
  - `start` during DECREMENTA → ignored.
- Prescaler (`BC_PRESCALER_EN`, PRESC=4): `valor`=3 → `cont` decrements every 4 cycles, `fim` after edge 13.

Source files
------------

// File: rtl/bc_temporizador_if.sv
// Host-side bundle of bc_temporizador: start/abort/auto/load value in, counter status out.
// Signal suffixes are taken from the timer's point of view.
interface bc_temporizador_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             abort_i;
  logic             auto_i;
  logic [WIDTH-1:0] valor_i;
  logic [WIDTH-1:0] cont_o;
  logic [7:0]       voltas_o;
  logic             ocupado_o;
  logic             pronto_o;
  logic             fim_o;

  modport master (
    output start_i, abort_i, auto_i, valor_i,
    input  cont_o, voltas_o, ocupado_o, pronto_o, fim_o
  );

  modport slave (
    input  start_i, abort_i, auto_i, valor_i,
    output cont_o, voltas_o, ocupado_o, pronto_o, fim_o
  );
endinterface

// File: rtl/bc_temporizador.sv
// Programmable countdown timer with optional auto-reload and saturating period counter.
// Optional feature: define BC_PRESCALER_EN to decrement once every PRESC cycles.
//
// state      | meaning
// OCIOSO     | idle, waiting for start
// CARGA      | load cont from valor, clear prescaler
// DECREMENTA | count down one step per tick
// FIM        | completion cycle, fim high, count the period
module bc_temporizador #(
  parameter int WIDTH = 8,
  parameter int PRESC = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  bc_temporizador_if.slave    bus
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    CARGA      = 2'b01,
    DECREMENTA = 2'b10,
    FIM        = 2'b11
  } estado_t;

  if (WIDTH < 2 || PRESC < 1) begin : g_param_err
    $error("bc_temporizador: WIDTH must be >= 2 and PRESC >= 1");
  end

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] cont_q, cont_d;
  logic [7:0]       voltas_q, voltas_d;
  logic             tick;

`ifdef BC_PRESCALER_EN
  localparam int PW = $clog2(PRESC + 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESC - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PRESC_TOP);

  always_comb begin
    presc_d = presc_q;
    if (state_q == CARGA) begin
      presc_d = '0;
    end else if (state_q == DECREMENTA) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= OCIOSO;
      cont_q   <= '0;
      voltas_q <= '0;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      voltas_q <= voltas_d;
    end
  end

  // abort wins over every transition out of a busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:     if (bus.start_i && !bus.abort_i) state_d = CARGA;
      CARGA:      if (bus.abort_i)                 state_d = OCIOSO;
                  else if (bus.valor_i == '0)      state_d = FIM;
                  else                             state_d = DECREMENTA;
      DECREMENTA: if (bus.abort_i)                 state_d = OCIOSO;
                  else if (tick && cont_q == WIDTH'(1)) state_d = FIM;
      FIM:        if (bus.abort_i)                 state_d = OCIOSO;
                  else if (bus.auto_i)             state_d = CARGA;
                  else                             state_d = OCIOSO;
      default:                                     state_d = OCIOSO;
    endcase
  end

  always_comb begin
    cont_d   = cont_q;
    voltas_d = voltas_q;
    case (state_q)
      OCIOSO: if (bus.start_i && !bus.abort_i) voltas_d = '0;
      CARGA:  cont_d = bus.abort_i ? '0 : bus.valor_i;
      DECREMENTA: begin
        if (bus.abort_i)                   cont_d = '0;
        else if (tick && cont_q != '0)     cont_d = cont_q - WIDTH'(1);
      end
      FIM: begin
        if (bus.abort_i)                   cont_d = '0;
        else if (voltas_q != 8'hFF)        voltas_d = voltas_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.cont_o    = cont_q;
    bus.voltas_o  = voltas_q;
    bus.pronto_o  = (state_q == OCIOSO);
    bus.ocupado_o = (state_q != OCIOSO);
    bus.fim_o     = (state_q == FIM);
  end

endmodule

// File: tb/tb_bc_temporizador.sv
// Randomized self-checking bench for bc_temporizador; expectations come from an
// edge-indexed arithmetic model of the countdown timeline.
module tb_bc_temporizador;
  localparam int WIDTH = 8;
  localparam int PRESC = 4;
`ifdef BC_PRESCALER_EN
  localparam int P = PRESC;
`else
  localparam int P = 1;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  bc_temporizador_if #(.WIDTH(WIDTH)) bus();
  bc_temporizador #(.WIDTH(WIDTH), .PRESC(PRESC)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Counter value seen after edge k of a run loaded with n (edge 0 samples start).
  function automatic int mdl_cont(input int n, input int k, input bit autorl);
    int per;
    int r;
    per = n * P + 2;
    r   = autorl ? (k - 1) % per : k - 1;
    if (r <= n * P) return n - r / P;
    return 0;
  endfunction

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.auto_i  = 1'b0;
    bus.valor_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) nxt();
    rst_ni = 1'b1;
    nxt();
    n_chk++;
    if ({bus.cont_o, bus.voltas_o, bus.pronto_o, bus.ocupado_o, bus.fim_o} !== {8'd0, 8'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_state: cont=%0d voltas=%0d pronto=%b ocupado=%b fim=%b, required 0 0 1 0 0",
               bus.cont_o, bus.voltas_o, bus.pronto_o, bus.ocupado_o, bus.fim_o);
    end
    bus.valor_i = 8'd5;
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    nxt();
    n_chk++;
    if (bus.cont_o !== 8'd5) begin
      n_fail++;
      $display("FAIL reset_preload: cont=%0d required 5", bus.cont_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({bus.cont_o, bus.voltas_o, bus.pronto_o, bus.ocupado_o, bus.fim_o} !== {8'd0, 8'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_async: cont=%0d voltas=%0d pronto=%b ocupado=%b fim=%b, required 0 0 1 0 0",
               bus.cont_o, bus.voltas_o, bus.pronto_o, bus.ocupado_o, bus.fim_o);
    end
    nxt();
    rst_ni = 1'b1;
    repeat (3) nxt();
    n_chk++;
    if ({bus.pronto_o, bus.cont_o} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_release: pronto=%b cont=%0d, required 1 0", bus.pronto_o, bus.cont_o);
    end
  endtask

  task automatic test_one_shot(input int n, input bit noise);
    logic [WIDTH-1:0] ec;
    logic ef, ep;
    idle_inputs();
    bus.valor_i = WIDTH'(n);
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    n_chk++;
    if (bus.ocupado_o !== 1'b1) begin
      n_fail++;
      $display("FAIL one_shot_load n=%0d: ocupado=%b required 1", n, bus.ocupado_o);
    end
    for (int k = 1; k <= n * P + 2; k++) begin
      nxt();
      ec = WIDTH'(mdl_cont(n, k, 1'b0));
      ef = (k == n * P + 1);
      ep = (k >= n * P + 2);
      n_chk++;
      if ({bus.cont_o, bus.fim_o, bus.pronto_o} !== {ec, ef, ep}) begin
        n_fail++;
        $display("FAIL one_shot n=%0d edge=%0d: cont=%0d fim=%b pronto=%b, required %0d %b %b",
                 n, k, bus.cont_o, bus.fim_o, bus.pronto_o, ec, ef, ep);
      end
      if (noise) begin
        bus.valor_i = WIDTH'($urandom);
        bus.start_i = (k == 1 && n * P >= 2);
      end
    end
    bus.start_i = 1'b0;
    n_chk++;
    if (bus.voltas_o !== 8'd1) begin
      n_fail++;
      $display("FAIL one_shot_voltas n=%0d: voltas=%0d required 1", n, bus.voltas_o);
    end
  endtask

  task automatic test_auto_reload(input int n);
    int per, k3, kend, fims;
    logic [WIDTH-1:0] ec;
    logic ef;
    per  = n * P + 2;
    k3   = n * P + 1 + 2 * per;
    kend = k3 + per;
    fims = 0;
    idle_inputs();
    bus.valor_i = WIDTH'(n);
    bus.auto_i  = 1'b1;
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    for (int k = 1; k <= kend + 1; k++) begin
      nxt();
      if (k <= kend) begin
        ec = WIDTH'(mdl_cont(n, k, 1'b1));
        ef = ((k - 1) % per == n * P);
        if (bus.fim_o === 1'b1) fims++;
        n_chk++;
        if ({bus.cont_o, bus.fim_o, bus.pronto_o} !== {ec, ef, 1'b0}) begin
          n_fail++;
          $display("FAIL auto n=%0d edge=%0d: cont=%0d fim=%b pronto=%b, required %0d %b 0",
                   n, k, bus.cont_o, bus.fim_o, bus.pronto_o, ec, ef);
        end
      end else begin
        n_chk++;
        if ({bus.pronto_o, bus.voltas_o} !== {1'b1, 8'd4}) begin
          n_fail++;
          $display("FAIL auto_stop n=%0d: pronto=%b voltas=%0d, required 1 4", n, bus.pronto_o, bus.voltas_o);
        end
      end
      if (k == k3 + 1) begin
        n_chk++;
        if (bus.voltas_o !== 8'd3) begin
          n_fail++;
          $display("FAIL auto_voltas3 n=%0d: voltas=%0d required 3", n, bus.voltas_o);
        end
        bus.auto_i = 1'b0;
      end
    end
    n_chk++;
    if (fims != 4) begin
      n_fail++;
      $display("FAIL auto_fim_count n=%0d: pulses=%0d required 4", n, fims);
    end
  endtask

  task automatic test_saturation();
    bit done;
    idle_inputs();
    bus.auto_i  = 1'b1;
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    repeat (520) nxt();
    bus.auto_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      nxt();
      done = (bus.pronto_o === 1'b1);
    end
    n_chk++;
    if (!done || bus.voltas_o !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation: pronto=%b voltas=%0d, required 1 255", bus.pronto_o, bus.voltas_o);
    end
  endtask

  task automatic test_abort_count(input int n);
    int ka;
    bit seen_fim;
    ka = 1 + (n - 2) * P;
    idle_inputs();
    bus.valor_i = WIDTH'(n);
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    repeat (ka) nxt();
    n_chk++;
    if (bus.cont_o !== 8'd2) begin
      n_fail++;
      $display("FAIL abort_pre n=%0d: cont=%0d required 2", n, bus.cont_o);
    end
    bus.abort_i = 1'b1;
    nxt();
    bus.abort_i = 1'b0;
    n_chk++;
    if ({bus.pronto_o, bus.cont_o, bus.fim_o} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_count n=%0d: pronto=%b cont=%0d fim=%b, required 1 0 0",
               n, bus.pronto_o, bus.cont_o, bus.fim_o);
    end
    seen_fim = 1'b0;
    repeat (n * P + 3) begin
      nxt();
      if (bus.fim_o !== 1'b0) seen_fim = 1'b1;
    end
    n_chk++;
    if (seen_fim || bus.voltas_o !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_after n=%0d: fim_seen=%b voltas=%0d, required 0 0", n, seen_fim, bus.voltas_o);
    end
  endtask

  task automatic test_abort_carga();
    idle_inputs();
    bus.valor_i = 8'd9;
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b1;
    nxt();
    bus.abort_i = 1'b0;
    n_chk++;
    if ({bus.pronto_o, bus.cont_o, bus.fim_o} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_carga: pronto=%b cont=%0d fim=%b, required 1 0 0",
               bus.pronto_o, bus.cont_o, bus.fim_o);
    end
  endtask

  task automatic test_abort_fim_and_idle();
    int n, per;
    n   = 2;
    per = n * P + 2;
    idle_inputs();
    bus.valor_i = WIDTH'(n);
    bus.auto_i  = 1'b1;
    bus.start_i = 1'b1;
    nxt();
    bus.start_i = 1'b0;
    repeat (n * P + 1 + per) nxt();
    n_chk++;
    if ({bus.fim_o, bus.voltas_o} !== {1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL abort_fim_pre: fim=%b voltas=%0d, required 1 1", bus.fim_o, bus.voltas_o);
    end
    bus.abort_i = 1'b1;
    nxt();
    bus.abort_i = 1'b0;
    bus.auto_i  = 1'b0;
    n_chk++;
    if ({bus.pronto_o, bus.voltas_o, bus.cont_o, bus.fim_o} !== {1'b1, 8'd1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_fim: pronto=%b voltas=%0d cont=%0d fim=%b, required 1 1 0 0",
               bus.pronto_o, bus.voltas_o, bus.cont_o, bus.fim_o);
    end
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    bus.valor_i = 8'd7;
    repeat (3) nxt();
    n_chk++;
    if ({bus.pronto_o, bus.ocupado_o, bus.voltas_o} !== {2'b10, 8'd1}) begin
      n_fail++;
      $display("FAIL start_abort_idle: pronto=%b ocupado=%b voltas=%0d, required 1 0 1",
               bus.pronto_o, bus.ocupado_o, bus.voltas_o);
    end
    idle_inputs();
    nxt();
  endtask

  initial begin
    test_reset();
    test_one_shot(5, 1'b0);
    test_one_shot(0, 1'b0);
    test_one_shot(1, 1'b0);
    test_one_shot(2, 1'b1);
    repeat (4) test_one_shot($urandom_range(3, 12), 1'b1);
    test_one_shot(255, 1'b1);
    test_auto_reload(3);
    test_auto_reload(0);
    test_auto_reload($urandom_range(1, 6));
    test_saturation();
    test_abort_count(3);
    test_abort_count($urandom_range(4, 12));
    test_abort_carga();
    test_abort_fim_and_idle();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
